// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter FSM states and the
// arbiter's latched request.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} arb_state_t;

  typedef struct packed {
    word_t addr;
    logic  wen;
    word_t store;
  } arb_req_t;

  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                           cnt_d = '0;
    else if (inc && cnt_q != W'(MAX))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: data first, with an
// instruction starvation guard and bounded retry on RAM ERROR.
module mem_arbiter import cpu_types_pkg::*; #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  arb_state_t state_q, state_d;
  arb_req_t   req_q, req_d;
  logic       drop_q, drop_d, bus_err_q, bus_err_d;
  logic [SW-1:0] streak;
  logic [RW-1:0] retry;
  logic       streak_inc, streak_clr, retry_inc, retry_clr;
  logic       granted, owner_req, done, err_done;
  word_t      load_w;
  ramstate_t  rs;

  assign rs = ramstate_t'(ramstate);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    drop_d     = 1'b0;
    bus_err_d  = bus_err_q;
    done       = 1'b0;
    err_done   = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    owner_req  = (state_q == DGRANT) ? (dREN | dWEN) : iREN;
    case (state_q)
      IDLE: begin
        if ((dREN | dWEN) && !(streak == SW'(STARVE_LIMIT) && iREN)) begin
          state_d = DGRANT;
          req_d   = '{addr: daddr, wen: dWEN, store: dstore};
        end else if (iREN) begin
          state_d = IGRANT;
          req_d   = '{addr: iaddr, wen: 1'b0, store: '0};
        end
      end
      default: begin
        // A dropped request aborts silently; RAM responses during the
        // enable-drop cycle belong to nothing and are ignored.
        if (!owner_req) state_d = IDLE;
        else if (!drop_q) begin
          if (rs == ACCESS) done = 1'b1;
          else if (rs == ERROR) begin
            if (retry == RW'(MAX_RETRY)) begin
              done      = 1'b1;
              err_done  = 1'b1;
              bus_err_d = 1'b1;
            end else begin
              retry_inc = 1'b1;
              drop_d    = 1'b1;
            end
          end
        end
      end
    endcase
    if (done) begin
      state_d   = IDLE;
      retry_clr = 1'b1;
      if (state_q == DGRANT && iREN) streak_inc = 1'b1;
      else                           streak_clr = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q   <= IDLE;
      req_q     <= '0;
      drop_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      drop_q    <= drop_d;
      bus_err_q <= bus_err_d;
    end

  arb_sat_counter #(.MAX(STARVE_LIMIT)) u_streak (
    .CLK(CLK), .nRST(nRST), .inc(streak_inc), .clr(streak_clr), .cnt(streak)
  );

  arb_sat_counter #(.MAX(MAX_RETRY)) u_retry (
    .CLK(CLK), .nRST(nRST), .inc(retry_inc), .clr(retry_clr), .cnt(retry)
  );

  assign granted  = (state_q != IDLE);
  assign ramREN   = granted && !drop_q && !req_q.wen;
  assign ramWEN   = granted && !drop_q && req_q.wen;
  assign ramaddr  = granted ? req_q.addr  : '0;
  assign ramstore = granted ? req_q.store : '0;

  assign load_w = err_done ? ARB_ERR_WORD : (req_q.wen ? '0 : ramload);
  assign iwait  = !(done && state_q == IGRANT);
  assign dwait  = !(done && state_q == DGRANT);
  assign iload  = (done && state_q == IGRANT) ? load_w : '0;
  assign dload  = (done && state_q == DGRANT) ? load_w : '0;
  assign bus_err = bus_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RAM model with programmable latency/error,
// a scoreboard queue filled by stimulus and drained by a wait-pulse monitor.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic iwait, dwait, ramREN, ramWEN, bus_err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int ram_lat = 0;
  bit ram_err = 1'b0;
  int ram_cnt = 0;
  int checks = 0, errors = 0;

  typedef struct { bit is_d; logic [31:0] data; logic [31:0] addr; } exp_t;
  exp_t sb[$];

  mem_arbiter #(.STARVE_LIMIT(4), .MAX_RETRY(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // RAM model: BUSY for ram_lat enabled cycles, then ACCESS (or ERROR).
  always_ff @(posedge CLK) ram_cnt <= (ramREN | ramWEN) ? ram_cnt + 1 : 0;

  always_comb begin
    ramstate = FREE;
    if (ramREN | ramWEN)
      ramstate = (ram_cnt >= ram_lat) ? (ram_err ? ERROR : ACCESS) : BUSY;
    case (ramaddr)
      32'h40:  ramload = 32'h8C010004;
      32'h44:  ramload = 32'h24020007;
      32'h80:  ramload = 32'h2468ACE0;
      32'h100: ramload = 32'hCAFEF00D;
      32'h300: ramload = 32'h13579BDF;
      default: ramload = 32'h0F0F0F0F;
    endcase
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] data, input logic [31:0] addr);
    exp_t e;
    e.is_d = is_d; e.data = data; e.addr = addr;
    sb.push_back(e);
  endtask

  // Monitor: every wait pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (nRST && (!iwait || !dwait)) begin
      if (sb.size() == 0) chk("unexpected_pulse", {iwait, dwait}, 2'b11);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("owner_is_data", !dwait, e.is_d);
        chk("other_wait_high", e.is_d ? iwait : dwait, 1'b1);
        chk("load_data", e.is_d ? dload : iload, e.data);
        chk("ram_addr", ramaddr, e.addr);
      end
    end
  end

  task automatic wait_low(input bit is_d, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge CLK);
      if ((is_d ? dwait : iwait) == 1'b0) begin cyc = i; break; end
    end
    if (cyc < 0) chk(is_d ? "dwait_timeout" : "iwait_timeout", 0, 1);
  endtask

  task automatic drain(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK); #1;
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", ok, 1'b1);
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [6:0] pat;

    // Reset values
    #3;
    chk("rst_waits", {iwait, dwait}, 2'b11);
    chk("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, '0);
    chk("rst_loads", {iload, dload, bus_err}, '0);
    step(); nRST = 1'b1;
    step();

    // T1: single instruction fetch, ACCESS 2 cycles after enable
    ram_lat = 2;
    iREN = 1'b1; iaddr = 32'h40;
    push(1'b0, 32'h8C010004, 32'h40);
    @(negedge CLK); chk("t1_idle_cycle", ramREN, 1'b0);
    @(negedge CLK); chk("t1_grant", {ramREN, ramWEN, ramaddr}, {2'b10, 32'h40});
    wait_low(1'b0, 10, cyc); chk("t1_latency", cyc, 2);
    step(); iREN = 1'b0;
    @(negedge CLK); chk("t1_after", {ramREN, iwait}, 2'b01);

    // T2: simultaneous requests, data first, then instruction after a gap
    step();
    ram_lat = 1;
    dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h44;
    push(1'b1, 32'hCAFEF00D, 32'h100);
    push(1'b0, 32'h24020007, 32'h44);
    wait_low(1'b1, 10, cyc);
    step(); dREN = 1'b0;
    @(negedge CLK); chk("t2_gap", ramREN, 1'b0);
    @(negedge CLK); chk("t2_igrant", {ramREN, ramaddr}, {1'b1, 32'h44});
    wait_low(1'b0, 10, cyc);
    step(); iREN = 1'b0;

    // T3: write (with dREN also high) held through 3 BUSY cycles
    step();
    ram_lat = 3;
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    push(1'b1, 32'h0, 32'h200);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t3_busy_hold", {ramREN, ramWEN, ramaddr, ramstore, dwait},
          {2'b01, 32'h200, 32'hDEADBEEF, 1'b1});
    end
    wait_low(1'b1, 5, cyc); chk("t3_access_cycle", cyc, 1);
    step(); dWEN = 1'b0; dREN = 1'b0;

    // T4: starvation guard: D x4, I, D x4, I with both requests held
    step();
    ram_lat = 1;
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1'b1, 32'h13579BDF, 32'h300);
      push(1'b0, 32'h2468ACE0, 32'h80);
    end
    drain(300);
    step(); iREN = 1'b0; dREN = 1'b0;

    // T5: ERROR on every attempt -> 3 reissues then forced error completion
    step();
    ram_lat = 0; ram_err = 1'b1;
    dREN = 1'b1; daddr = 32'h400;
    push(1'b1, 32'hBAD1BAD1, 32'h400);
    @(negedge CLK);
    pat = '0;
    for (int i = 6; i >= 0; i--) begin
      @(negedge CLK);
      pat[i] = ramREN;
      if (i == 1) chk("t5_no_err_yet", bus_err, 1'b0);
    end
    chk("t5_enable_pattern", pat, 7'b1010101);
    chk("t5_final_dwait", dwait, 1'b0);
    step(); dREN = 1'b0; ram_err = 1'b0;
    @(negedge CLK); chk("t5_bus_err_set", bus_err, 1'b1);

    // T6: owner drops request mid-grant -> abort, no dwait pulse
    step();
    ram_lat = 5;
    dREN = 1'b1; daddr = 32'h600;
    @(negedge CLK);
    @(negedge CLK); chk("t6_grant", ramREN, 1'b1);
    step(); dREN = 1'b0;
    @(negedge CLK); chk("t6_abort_cycle_dwait", dwait, 1'b1);
    @(negedge CLK); chk("t6_idle", {ramREN, ramaddr, dwait}, {1'b0, 32'h0, 1'b1});
    repeat (3) @(negedge CLK);
    chk("t6_bus_err_sticky", bus_err, 1'b1);

    // T7: asynchronous reset mid-DGRANT
    step();
    dREN = 1'b1; daddr = 32'h700;
    @(negedge CLK);
    @(negedge CLK); chk("t7_grant", {ramREN, ramaddr}, {1'b1, 32'h700});
    #2 nRST = 1'b0;
    #1;
    chk("t7_rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, '0);
    chk("t7_rst_misc", {iwait, dwait, iload, dload, bus_err}, {2'b11, 65'h0});
    dREN = 1'b0;
    step(); nRST = 1'b1;
    @(negedge CLK); chk("t7_idle_after", {ramREN, ramWEN}, 2'b00);

    // T8: normal fetch after reset
    step();
    ram_lat = 0;
    iREN = 1'b1; iaddr = 32'h40;
    push(1'b0, 32'h8C010004, 32'h40);
    wait_low(1'b0, 10, cyc); chk("t8_latency", cyc, 2);
    step(); iREN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
